// File: rtl/spi_slave_burst.sv
// SPI slave bridging a burst-framed SPI master (command + address header, then DW-bit words)
// onto the DLA register/memory bus, with read prefetch and protocol error flags.
module spi_slave_burst #(
    parameter int unsigned CW   = 2,
    parameter int unsigned AW   = 19,
    parameter int unsigned DW   = 16,
    parameter int unsigned CPOL = 0,
    parameter int unsigned CPHA = 0,
    parameter int unsigned CNT  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_clk,
    input  logic          spi_csn,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    output logic [AW-1:0] mosi_addr,
    output logic          mosi_wen,
    output logic          mosi_ren,
    output logic [DW-1:0] mosi_data,
    input  logic [DW-1:0] miso_data,
    input  logic          miso_data_valid,
    output logic          frame_err,
    output logic          rd_underflow
);

    localparam int unsigned HW        = CW + AW;
    localparam logic [CNT-1:0] HDR_LAST  = CNT'(HW - 1);
    localparam logic [CNT-1:0] WORD_LAST = CNT'(DW - 1);
    localparam logic [CW-1:0]  CMD_WR    = CW'(2);
    localparam logic [CW-1:0]  CMD_RD    = CW'(1);
    localparam logic           IDLE_LVL  = 1'(CPOL);
    localparam bit             SAMPLE_ON_TRAIL = (CPHA != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Pin synchronizers plus one history stage for edge detection
    logic clk_meta, clk_sync, clk_prev;
    logic csn_meta, csn_sync, csn_prev;
    logic mosi_meta, mosi_sync;

    logic [CNT-1:0] bit_cnt;
    logic [HW-2:0]  hdr_shift;
    logic [DW-2:0]  rx_shift;
    logic [DW-1:0]  tx_shift;
    logic [CW-1:0]  cmd;
    logic [AW-1:0]  addr_next;
    logic           word_seen;
    logic           rd_pend;
    logic           buf_valid;
    logic [DW-1:0]  buf_data;

    logic lead_c, trail_c, sample_c, shift_c;
    logic csn_fall_c, csn_rise_c;
    logic hdr_bit_c, hdr_done_c, data_bit_c, word_done_c;
    logic load_c, advance_c, frame_end_c, err_c;
    logic [HW-1:0] hdr_full_c;
    logic [CW-1:0] hdr_cmd_c;
    logic [AW-1:0] hdr_addr_c;
    logic [DW-1:0] rx_full_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_meta  <= 1'b0;
            clk_sync  <= 1'b0;
            clk_prev  <= 1'b0;
            csn_meta  <= 1'b0;
            csn_sync  <= 1'b0;
            csn_prev  <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            clk_meta  <= spi_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            csn_meta  <= spi_csn;
            csn_sync  <= csn_meta;
            csn_prev  <= csn_sync;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign lead_c     = (clk_prev == IDLE_LVL) && (clk_sync != IDLE_LVL);
    assign trail_c    = (clk_prev != IDLE_LVL) && (clk_sync == IDLE_LVL);
    assign sample_c   = SAMPLE_ON_TRAIL ? trail_c : lead_c;
    assign shift_c    = SAMPLE_ON_TRAIL ? lead_c : trail_c;
    assign csn_fall_c = csn_prev & ~csn_sync;
    assign csn_rise_c = ~csn_prev & csn_sync;

    assign hdr_full_c = {hdr_shift, mosi_sync};
    assign hdr_cmd_c  = hdr_full_c[HW-1 -: CW];
    assign hdr_addr_c = hdr_full_c[AW-1:0];
    assign rx_full_c  = {rx_shift, mosi_sync};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-clk datapath strobes; csn rising overrides any coincident edge
    always_comb begin
        state_nxt   = state;
        hdr_bit_c   = 1'b0;
        hdr_done_c  = 1'b0;
        data_bit_c  = 1'b0;
        word_done_c = 1'b0;
        load_c      = 1'b0;
        advance_c   = 1'b0;
        frame_end_c = 1'b0;
        err_c       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (csn_fall_c) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (csn_rise_c) begin
                    state_nxt   = ST_IDLE;
                    frame_end_c = 1'b1;
                    err_c       = 1'b1;
                end else if (sample_c) begin
                    hdr_bit_c = 1'b1;
                    if (bit_cnt == HDR_LAST) begin
                        hdr_done_c = 1'b1;
                        state_nxt  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (csn_rise_c) begin
                    state_nxt   = ST_IDLE;
                    frame_end_c = 1'b1;
                    err_c       = (bit_cnt != '0) || !word_seen;
                end else begin
                    if (sample_c) begin
                        data_bit_c  = 1'b1;
                        word_done_c = (bit_cnt == WORD_LAST);
                    end
                    if (shift_c && (cmd == CMD_RD)) begin
                        if (bit_cnt == '0) load_c    = 1'b1;
                        else               advance_c = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            hdr_shift    <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            cmd          <= '0;
            addr_next    <= '0;
            word_seen    <= 1'b0;
            rd_pend      <= 1'b0;
            buf_valid    <= 1'b0;
            buf_data     <= '0;
            spi_miso_oe  <= 1'b0;
            mosi_addr    <= '0;
            mosi_wen     <= 1'b0;
            mosi_ren     <= 1'b0;
            mosi_data    <= '0;
            frame_err    <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            mosi_wen     <= 1'b0;
            mosi_ren     <= 1'b0;
            rd_underflow <= 1'b0;
            frame_err    <= err_c;

            if ((state == ST_IDLE) && csn_fall_c) begin
                bit_cnt   <= '0;
                word_seen <= 1'b0;
            end

            if (hdr_bit_c) begin
                hdr_shift <= hdr_full_c[HW-2:0];
                bit_cnt   <= hdr_done_c ? '0 : bit_cnt + CNT'(1);
            end

            // Header complete: reads issue the first request right away
            if (hdr_done_c) begin
                cmd <= hdr_cmd_c;
                if (hdr_cmd_c == CMD_RD) begin
                    mosi_ren  <= 1'b1;
                    mosi_addr <= hdr_addr_c;
                    addr_next <= hdr_addr_c + AW'(1);
                    rd_pend   <= 1'b1;
                end else begin
                    addr_next <= hdr_addr_c;
                end
            end

            if (data_bit_c) begin
                rx_shift <= rx_full_c[DW-2:0];
                bit_cnt  <= word_done_c ? '0 : bit_cnt + CNT'(1);
            end

            if (word_done_c) begin
                word_seen <= 1'b1;
                if (cmd == CMD_WR) begin
                    mosi_wen  <= 1'b1;
                    mosi_data <= rx_full_c;
                    mosi_addr <= addr_next;
                    addr_next <= addr_next + AW'(1);
                end
            end

            // Only the reply to an outstanding request is accepted
            if (miso_data_valid && rd_pend) begin
                buf_data  <= miso_data;
                buf_valid <= 1'b1;
                rd_pend   <= 1'b0;
            end

            if (load_c) begin
                spi_miso_oe <= 1'b1;
                if (buf_valid) begin
                    tx_shift <= buf_data;
                end else begin
                    tx_shift     <= '0;
                    rd_underflow <= 1'b1;
                end
                buf_valid <= 1'b0;
                mosi_ren  <= 1'b1;
                mosi_addr <= addr_next;
                addr_next <= addr_next + AW'(1);
                rd_pend   <= 1'b1;
            end

            if (advance_c) tx_shift <= {tx_shift[DW-2:0], 1'b0};

            if (frame_end_c) begin
                spi_miso_oe <= 1'b0;
                rd_pend     <= 1'b0;
                buf_valid   <= 1'b0;
                tx_shift    <= '0;
                bit_cnt     <= '0;
            end
        end
    end

    assign spi_miso = tx_shift[DW-1];

endmodule

// File: tb/tb_spi_slave_burst.sv
// Bench for spi_slave_burst: three instances (modes 0, 1, 3) driven by a bit-level SPI master
// and a DLA responder; bus activity and MISO words are compared against burst-level expectations.
module tb_spi_slave_burst;

    localparam int HALF = 8;
    localparam bit [2:0] CPHA_OF = 3'b110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sclk_raw = 1'b0;
    logic [2:0]  csn = 3'b111;
    logic        mosi = 1'b0;
    logic [15:0] miso_data = '0;
    logic        miso_data_valid = 1'b0;

    logic [2:0]  miso, oe, wen, ren, ferr, unf;
    logic [18:0] addr [3];
    logic [15:0] wdata [3];

    spi_slave_burst #(.CPOL(0), .CPHA(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk_raw), .spi_csn(csn[0]), .spi_mosi(mosi),
        .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .mosi_addr(addr[0]), .mosi_wen(wen[0]),
        .mosi_ren(ren[0]), .mosi_data(wdata[0]), .miso_data(miso_data),
        .miso_data_valid(miso_data_valid), .frame_err(ferr[0]), .rd_underflow(unf[0]));

    spi_slave_burst #(.CPOL(0), .CPHA(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sclk_raw), .spi_csn(csn[1]), .spi_mosi(mosi),
        .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .mosi_addr(addr[1]), .mosi_wen(wen[1]),
        .mosi_ren(ren[1]), .mosi_data(wdata[1]), .miso_data(miso_data),
        .miso_data_valid(miso_data_valid), .frame_err(ferr[1]), .rd_underflow(unf[1]));

    spi_slave_burst #(.CPOL(1), .CPHA(1)) u_m3 (
        .clk(clk), .rst_n(rst_n), .spi_clk(~sclk_raw), .spi_csn(csn[2]), .spi_mosi(mosi),
        .spi_miso(miso[2]), .spi_miso_oe(oe[2]), .mosi_addr(addr[2]), .mosi_wen(wen[2]),
        .mosi_ren(ren[2]), .mosi_data(wdata[2]), .miso_data(miso_data),
        .miso_data_valid(miso_data_valid), .frame_err(ferr[2]), .rd_underflow(unf[2]));

    typedef struct packed {
        logic [18:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         wen_q [$];
    logic [18:0] ren_q [$];
    logic [15:0] reply_q [$];
    logic [15:0] wq [$];
    bit          miso_bits [$];
    bit          dla_en = 1'b1;
    bit          hdr_oe, data_oe;
    int          err_cnt, unf_cnt;
    int          sel = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and DLA model: replies one clk after each request of the selected instance
    always @(negedge clk) begin
        miso_data_valid = 1'b0;
        if (rst_n) begin
            if (wen[sel]) wen_q.push_back({addr[sel], wdata[sel]});
            if (ren[sel]) begin
                ren_q.push_back(addr[sel]);
                if (dla_en) begin
                    if (reply_q.size() > 0) miso_data = reply_q.pop_front();
                    else                    miso_data = 16'hDEAD;
                    miso_data_valid = 1'b1;
                end
            end
            if (ferr[sel]) err_cnt++;
            if (unf[sel])  unf_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_frame(input int s, input logic [1:0] c, input logic [18:0] a,
                            input int nhdr, input int ndata, input bit keep);
        bit bits [$];
        logic [20:0] hdr;
        hdr = {c, a};
        for (int i = 20; i >= 21 - nhdr; i--) bits.push_back(hdr[i]);
        for (int i = 0; i < ndata; i++) bits.push_back(wq[i / 16][15 - (i % 16)]);
        miso_bits.delete();
        wen_q.delete();
        ren_q.delete();
        err_cnt = 0;
        unf_cnt = 0;
        hdr_oe  = 1'b0;
        data_oe = 1'b0;
        sel     = s;
        @(negedge clk);
        csn[s] = 1'b0;
        wait_clk(HALF);
        foreach (bits[i]) begin
            if (CPHA_OF[s] == 1'b0) begin
                mosi = bits[i];
                wait_clk(HALF);
            end else begin
                sclk_raw = 1'b1;
                mosi = bits[i];
                wait_clk(HALF);
            end
            miso_bits.push_back(miso[s]);
            if (i < 21) hdr_oe = hdr_oe | oe[s];
            else        data_oe = oe[s];
            sclk_raw = ~sclk_raw;
            wait_clk(HALF);
            if (CPHA_OF[s] == 1'b0) sclk_raw = 1'b0;
        end
        wait_clk(HALF);
        if (!keep) begin
            csn[s] = 1'b1;
            wait_clk(12);
        end
    endtask

    task automatic check_writes(input string tag, input logic [18:0] base, input int n,
                                input int exp_err);
        check({tag, "_wen_n"}, 64'(wen_q.size()), 64'(n));
        for (int i = 0; i < n && i < wen_q.size(); i++) begin
            check({tag, "_wen_addr"}, 64'(wen_q[i].a), 64'(19'(base + i)));
            check({tag, "_wen_data"}, 64'(wen_q[i].d), 64'(wq[i]));
        end
        check({tag, "_ren_n"}, 64'(ren_q.size()), 64'd0);
        check({tag, "_ferr"}, 64'(err_cnt), 64'(exp_err));
        check({tag, "_oe_data"}, 64'(data_oe), 64'd0);
    endtask

    // Reads in CPHA=1 modes: one request at header end plus one per word loaded
    task automatic check_reads(input string tag, input logic [18:0] base, input int n,
                               input int exp_unf);
        logic [15:0] v;
        check({tag, "_ren_n"}, 64'(ren_q.size()), 64'(n + 1));
        for (int i = 0; i <= n && i < ren_q.size(); i++)
            check({tag, "_ren_addr"}, 64'(ren_q[i]), 64'(19'(base + i)));
        for (int k = 0; k < n; k++) begin
            v = '0;
            for (int b = 0; b < 16; b++) v = {v[14:0], miso_bits[21 + 16 * k + b]};
            check({tag, "_miso_word"}, 64'(v), 64'(wq[k]));
        end
        check({tag, "_unf"}, 64'(unf_cnt), 64'(exp_unf));
        check({tag, "_ferr"}, 64'(err_cnt), 64'd0);
        check({tag, "_wen_n"}, 64'(wen_q.size()), 64'd0);
        check({tag, "_oe_hdr"}, 64'(hdr_oe), 64'd0);
        check({tag, "_oe_data"}, 64'(data_oe), 64'd1);
        check({tag, "_oe_after"}, 64'(oe[sel]), 64'd0);
    endtask

    initial begin
        logic [18:0] a;
        int n, s;

        wait_clk(4);
        check("rst_wen", 64'(wen), 64'd0);
        check("rst_ren", 64'(ren), 64'd0);
        check("rst_oe", 64'(oe), 64'd0);
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_addr", 64'(addr[0]), 64'd0);
        check("rst_flags", 64'({ferr, unf}), 64'd0);
        rst_n = 1'b1;
        wait_clk(6);

        wq.delete(); wq.push_back(16'hBEEF);
        do_frame(0, 2'b10, 19'h00123, 21, 16, 1'b0);
        check_writes("m0_single", 19'h00123, 1, 0);

        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
        do_frame(2, 2'b10, 19'h7FFFE, 21, 64, 1'b0);
        check_writes("m3_wrap", 19'h7FFFE, 4, 0);

        wq.delete(); wq.push_back(16'hA5A5); wq.push_back(16'h0F0F); wq.push_back(16'h1234);
        reply_q.delete();
        reply_q.push_back(16'hA5A5); reply_q.push_back(16'h0F0F);
        reply_q.push_back(16'h1234); reply_q.push_back(16'h5555);
        do_frame(1, 2'b01, 19'h00010, 21, 48, 1'b0);
        check_reads("m1_read", 19'h00010, 3, 0);

        dla_en = 1'b0;
        wq.delete(); wq.push_back(16'h0000); wq.push_back(16'h0000);
        do_frame(1, 2'b01, 19'h00200, 21, 32, 1'b0);
        check_reads("m1_unf", 19'h00200, 2, 2);
        dla_en = 1'b1;
        reply_q.delete();

        wq.delete(); wq.push_back(16'h1357); wq.push_back(16'hFFFF);
        do_frame(0, 2'b10, 19'h00400, 21, 16 + 9, 1'b0);
        check_writes("m0_abort", 19'h00400, 1, 1);

        wq.delete(); wq.push_back(16'h2468);
        do_frame(0, 2'b10, 19'h00500, 21, 16, 1'b0);
        check_writes("m0_after_abort", 19'h00500, 1, 0);

        do_frame(0, 2'b10, 19'h00600, 10, 0, 1'b0);
        check_writes("m0_hdr_abort", 19'h00600, 0, 1);

        do_frame(2, 2'b10, 19'h00700, 21, 0, 1'b0);
        check_writes("m3_no_word", 19'h00700, 0, 1);

        wq.delete(); wq.push_back(16'hCAFE); wq.push_back(16'hF00D);
        do_frame(0, 2'b11, 19'h00800, 21, 32, 1'b0);
        check_writes("m0_unknown", 19'h00800, 0, 0);

        for (int t = 0; t < 6; t++) begin
            s = $urandom_range(0, 2);
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) a = 19'($urandom);
            else                           a = 19'(19'h7FFFD + $urandom_range(0, 2));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
            do_frame(s, 2'b10, a, 21, 16 * n, 1'b0);
            check_writes("rnd_wr", a, n, 0);
        end

        for (int t = 0; t < 4; t++) begin
            s = $urandom_range(1, 2);
            n = $urandom_range(1, 3);
            a = 19'($urandom);
            wq.delete();
            reply_q.delete();
            for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
            foreach (wq[i]) reply_q.push_back(wq[i]);
            reply_q.push_back(16'($urandom));
            do_frame(s, 2'b01, a, 21, 16 * n, 1'b0);
            check_reads("rnd_rd", a, n, 0);
        end

        wq.delete(); wq.push_back(16'hFFFF); wq.push_back(16'hFFFF);
        reply_q.delete(); reply_q.push_back(16'hFFFF); reply_q.push_back(16'hFFFF);
        do_frame(2, 2'b01, 19'h01234, 21, 16 + 5, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_wen_ren", 64'({wen[2], ren[2]}), 64'd0);
        check("rstmid_oe", 64'(oe[2]), 64'd0);
        check("rstmid_miso", 64'(miso[2]), 64'd0);
        check("rstmid_addr", 64'(addr[2]), 64'd0);
        check("rstmid_data", 64'(wdata[2]), 64'd0);
        check("rstmid_flags", 64'({ferr[2], unf[2]}), 64'd0);
        csn[2] = 1'b1;
        sclk_raw = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(6);

        wq.delete(); wq.push_back(16'h5A5A); wq.push_back(16'h0001);
        do_frame(2, 2'b10, 19'h03000, 21, 32, 1'b0);
        check_writes("post_rst", 19'h03000, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
Next-generation SPI slave bridging an external SPI master to the DLA register/memory bus. All SPI pins are sampled in the single system clock domain; the block runs in any of the four SPI modes, set by parameter. Frames are bursts: one command+address header followed by any number of DW-bit data words, with the address auto-incrementing per word. Reads are prefetched through a valid handshake, and protocol errors are flagged.

Parameters:
CW, 2, command width; 2'b10 = write, 2'b01 = read, other codes ignored (frame consumed, no bus activity)
AW, 19, address width
DW, 16, data word width
CPOL, 0, SPI clock idle level
CPHA, 0, 0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge
CNT, 6, bit counter width; must satisfy 2^CNT > CW+AW and 2^CNT > DW

Ports:
clk  in  1  system clock, >= 8x SCLK frequency
rst_n  in  1  synchronous reset, active low
spi_clk  in  1  SPI clock, asynchronous to clk
spi_csn  in  1  chip select, active low
spi_mosi  in  1  serial data in, MSB first
spi_miso  out  1  serial data out, MSB first
spi_miso_oe  out  1  output enable for the pad tristate
mosi_addr  out  AW  bus address for the current wen/ren
mosi_wen  out  1  write strobe, one clk pulse
mosi_ren  out  1  read request, one clk pulse
mosi_data  out  DW  write data, valid with mosi_wen
miso_data  in  DW  read data
miso_data_valid  in  1  read data valid, one clk
frame_err  out  1  one-clk pulse: csn rose mid-header or mid-word
rd_underflow  out  1  one-clk pulse: read word needed before data was returned

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, state IDLE, counters cleared, synchronizers cleared. Reset has priority over every other event.
- spi_clk, spi_csn and spi_mosi pass through a 2-FF synchronizer. Edges are detected on the synchronized spi_clk. Leading edge = transition away from CPOL. Sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other edge.
- States:
  - IDLE -> HDR on synced csn falling.
  - HDR: shift in CW+AW bits on sample edges. After the last bit: latch cmd, latch base address, clear word index, go to DATA.
  - DATA: loops per DW-bit word until csn rises.
  - Any state -> IDLE on synced csn rising.
- Write (cmd 10): after the DW-th sample of each word, mosi_wen pulses for exactly 1 clk. mosi_data = received word; mosi_addr = base + index. Index then increments.
- Read (cmd 01):
  - mosi_ren pulses 1 clk after the header completes, with mosi_addr = base.
  - The first miso_data_valid latches into a prefetch buffer.
  - On the first shift edge of each word, the buffer loads into the tx shifter. mosi_ren then pulses for base + index + 1 (prefetch).
  - Subsequent shift edges advance the shifter. spi_miso = shifter MSB.
  - spi_miso_oe = 1 from the first shift edge of DATA until csn rises; 0 otherwise.
  - If the buffer is empty at a load, the shifter loads 0 and rd_underflow pulses.
  - miso_data_valid with no request outstanding is ignored.
- Address arithmetic is modulo 2^AW: address all-ones is followed by 0.
- csn rising:
  - At a word boundary (bit count 0, at least one complete data word): clean end, no pulse.
  - In HDR or mid-word: frame_err pulses 1 clk, the partial word is discarded, and no wen is issued for it.
  - In either case an outstanding read reply is dropped, and spi_miso_oe clears within 3 clk.
- csn rising and a sample edge in the same clk: csn wins and the sample is discarded.
- Unknown command: bits are still counted (frame_err rules apply). No wen, no ren, oe stays 0.
- Read latency budget: the DLA must assert miso_data_valid within 2 clk of mosi_ren to avoid underflow at the maximum SCLK.

Test Plan:
- Mode 0, single write: header 10 + addr 0x00123, data 0xBEEF -> one wen pulse with addr 0x00123, data 0xBEEF; frame_err stays 0.
- Mode 3, 4-word write burst at addr 0x7FFFE -> wen addrs 0x7FFFE, 0x7FFFF, 0x00000, 0x00001 (wrap), data matching MOSI.
- Mode 1 read burst of 3 words at 0x00010, DLA returns 0xA5A5, 0x0F0F, 0x1234 with 1-clk latency -> ren for 0x10, 0x11, 0x12, 0x13 (last is prefetch); MISO carries the three words MSB-first; oe low outside DATA.
- Read with DLA never asserting valid -> MISO 0x0000, one rd_underflow pulse per word, no hang.
- csn raised after 9 data bits of a write word -> frame_err pulse, no wen for the partial word; the next frame decodes correctly.
- rst_n low mid-burst -> all outputs 0 the next clk; a clean write after reset succeeds.
